// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end: input synchroniser, deframing FSM and a
// one-entry receive buffer with sticky framing/overrun flags for MMIO readout.
module uart_rx_frontend #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_err,
  output logic       overrun,
  input  logic       err_clear
);

  localparam int BIT_T  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_T = BIT_T / 2;
  localparam int CNT_W  = $clog2(BIT_T);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_T - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_T - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [1:0]       sync_r;
  logic             rx_s;
  logic [2:0]       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [2:0]       bit_idx_r, bit_idx_nx_s;
  logic [7:0]       shreg_r, shreg_nx_s;
  logic             stop_ok_s, stop_bad_s;
  logic [7:0]       data_nx_s;
  logic             valid_nx_s, ovr_set_s, ovr_nx_s, fe_nx_s;

  assign rx_s = sync_r[1];

  // Deframing FSM next-state; the start bit is re-checked at mid-bit to reject glitches
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    bit_idx_nx_s = bit_idx_r;
    shreg_nx_s   = shreg_r;
    stop_ok_s    = 1'b0;
    stop_bad_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nx_s = START;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nx_s = CNT_ZERO;
          if (!rx_s) begin
            state_nx_s   = DATA;
            bit_idx_nx_s = 3'd0;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          shreg_nx_s   = {rx_s, shreg_r[7:1]};
          cnt_nx_s     = CNT_ZERO;
          bit_idx_nx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_nx_s = STOP;
          end else begin
            state_nx_s = DATA;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nx_s = CNT_ZERO;
          if (rx_s) begin
            stop_ok_s  = 1'b1;
            state_nx_s = IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_nx_s = BREAK;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = BREAK;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Buffer update: a pop in the delivery cycle frees the slot for the new byte
  always_comb begin
    data_nx_s  = data_out;
    valid_nx_s = data_out_valid;
    ovr_set_s  = 1'b0;
    if (stop_ok_s) begin
      if (!data_out_valid || data_out_ready) begin
        data_nx_s  = shreg_r;
        valid_nx_s = 1'b1;
      end else begin
        ovr_set_s = 1'b1;
      end
    end else if (data_out_valid && data_out_ready) begin
      valid_nx_s = 1'b0;
    end else begin
      valid_nx_s = data_out_valid;
    end
    if (ovr_set_s) begin
      ovr_nx_s = 1'b1;
    end else if (err_clear) begin
      ovr_nx_s = 1'b0;
    end else begin
      ovr_nx_s = overrun;
    end
    if (stop_bad_s) begin
      fe_nx_s = 1'b1;
    end else if (err_clear) begin
      fe_nx_s = 1'b0;
    end else begin
      fe_nx_s = framing_err;
    end
  end

  // State, synchroniser and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r         <= 2'b11;
      state_r        <= IDLE;
      cnt_r          <= CNT_ZERO;
      bit_idx_r      <= 3'd0;
      shreg_r        <= 8'h00;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      framing_err    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      sync_r         <= {sync_r[0], serial_in};
      state_r        <= state_nx_s;
      cnt_r          <= cnt_nx_s;
      bit_idx_r      <= bit_idx_nx_s;
      shreg_r        <= shreg_nx_s;
      data_out       <= data_nx_s;
      data_out_valid <= valid_nx_s;
      framing_err    <= fe_nx_s;
      overrun        <= ovr_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at BIT_T=10, HALF_T=5.
module tb_uart_rx_frontend;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_err;
  logic       overrun;
  logic       err_clear;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  uart_rx_frontend #(.CLOCK_FREQ(100), .BAUD_RATE(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_err    (framing_err),
    .overrun        (overrun),
    .err_clear      (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; each bit lasts 10 clocks
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (10) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic pop();
    data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
  endtask

  task automatic clear_flags();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", {7'd0, data_out_valid}, 8'h00);
    check("rst_fe", {7'd0, framing_err}, 8'h00);
    check("rst_ovr", {7'd0, overrun}, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: basic byte and latency
    lat = 0;
    fork
      send(8'hA5);
      begin
        while (!data_out_valid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("t1_latency_in_96_98", {7'd0, (lat >= 96 && lat <= 98)}, 8'h01);
    check("t1_data", data_out, 8'hA5);
    repeat (10) @(negedge clk);
    check("t1_valid_held", {7'd0, data_out_valid}, 8'h01);
    pop();
    check("t1_valid_after_pop", {7'd0, data_out_valid}, 8'h00);
    check("t1_data_kept", data_out, 8'hA5);

    // 2: overrun on second byte without pop
    send(8'h3C);
    send(8'h81);
    check("t2_data", data_out, 8'h3C);
    check("t2_valid", {7'd0, data_out_valid}, 8'h01);
    check("t2_ovr", {7'd0, overrun}, 8'h01);
    clear_flags();
    check("t2_ovr_cleared", {7'd0, overrun}, 8'h00);

    // 3: pop exactly in the stop-sample cycle
    fork
      send(8'h81);
      begin
        repeat (97) @(negedge clk);
        check("t3_pre_valid", {7'd0, data_out_valid}, 8'h01);
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
      end
    join
    check("t3_data", data_out, 8'h81);
    check("t3_valid", {7'd0, data_out_valid}, 8'h01);
    check("t3_ovr", {7'd0, overrun}, 8'h00);
    pop();

    // 4: 3-cycle glitch is rejected
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_valid", {7'd0, data_out_valid}, 8'h00);
    check("t4_fe", {7'd0, framing_err}, 8'h00);
    send(8'h55);
    check("t4_data", data_out, 8'h55);
    check("t4_valid_after", {7'd0, data_out_valid}, 8'h01);
    pop();

    // 5: framing error, break, then recovery
    send_frame(8'hFF, 1'b0);
    repeat (30) @(negedge clk);
    check("t5_fe", {7'd0, framing_err}, 8'h01);
    check("t5_valid", {7'd0, data_out_valid}, 8'h00);
    serial_in = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h12);
    check("t5_data", data_out, 8'h12);
    check("t5_valid_after", {7'd0, data_out_valid}, 8'h01);
    check("t5_fe_sticky", {7'd0, framing_err}, 8'h01);
    clear_flags();
    check("t5_fe_cleared", {7'd0, framing_err}, 8'h00);

    // 6: reset during data bit 4 (line high at release)
    fork
      send(8'hF0);
      begin
        repeat (55) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", {7'd0, data_out_valid}, 8'h00);
        check("t6_rst_data", data_out, 8'h00);
        check("t6_rst_fe", {7'd0, framing_err}, 8'h00);
        check("t6_rst_ovr", {7'd0, overrun}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check("t6_no_byte_valid", {7'd0, data_out_valid}, 8'h00);
    check("t6_no_byte_data", data_out, 8'h00);
    send(8'h7E);
    check("t6_data", data_out, 8'h7E);
    check("t6_valid", {7'd0, data_out_valid}, 8'h01);
    check("t6_ovr", {7'd0, overrun}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
